// File: rtl/mvm_axis_loader.sv
// mvm_axis_loader: upstream injection sequencer for mvm_top.
//
// Takes a stream of 2*DATAW weight words and one DATAW input-vector word.
// Each weight word becomes two single-flit AXIS packets: the upper half
// goes to router d and the lower half to router d+1. Each packet carries the
// RF address, op 2'b11 and a one-hot lane bit in TUSER. Once every pair has
// been loaded, the vector word is sent as one packet with op 2'b10 to
// CFG_VEC_DEST, which triggers compute.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   START                     one-cycle pulse; begins a load when idle
//   CFG_BASE_DEST/NUM_PAIRS/RF_ADDR/VEC_DEST
//                             load configuration, latched on START
//   BUSY, DONE                load in progress / one-cycle completion pulse
//   WGT_TVALID/TREADY/TDATA   weight word stream (upper half -> dest d)
//   VEC_TVALID/TREADY/TDATA   input vector stream
//   AXIS_M_*                  single-flit AXIS master towards mvm_top
//
// TUSER layout: [8:0] RF address, [10:9] op, [10+LANES:11] one-hot lane.
module mvm_axis_loader #(
  parameter int unsigned DATAW    = 512,
  parameter int unsigned DESTW    = 12,
  parameter int unsigned IDW      = 4,
  parameter int unsigned LANES    = 64,
  parameter int unsigned RF_ADDRW = 9,
  parameter int unsigned USERW    = 75,
  parameter int unsigned PAIRW    = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DESTW-1:0]     CFG_BASE_DEST,
  input  logic [PAIRW-1:0]     CFG_NUM_PAIRS,
  input  logic [RF_ADDRW-1:0]  CFG_RF_ADDR,
  input  logic [DESTW-1:0]     CFG_VEC_DEST,
  output logic                 BUSY,
  output logic                 DONE,
  input  logic                 WGT_TVALID,
  output logic                 WGT_TREADY,
  input  logic [2*DATAW-1:0]   WGT_TDATA,
  input  logic                 VEC_TVALID,
  output logic                 VEC_TREADY,
  input  logic [DATAW-1:0]     VEC_TDATA,
  output logic                 AXIS_M_TVALID,
  input  logic                 AXIS_M_TREADY,
  output logic [DATAW-1:0]     AXIS_M_TDATA,
  output logic                 AXIS_M_TLAST,
  output logic [IDW-1:0]       AXIS_M_TID,
  output logic [USERW-1:0]     AXIS_M_TUSER,
  output logic [DESTW-1:0]     AXIS_M_TDEST
);

  localparam int unsigned LANEW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [1:0]  OP_WGT = 2'b11;
  localparam logic [1:0]  OP_VEC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WGT,
    S_SEND_HI,
    S_SEND_LO,
    S_WAIT_VEC,
    S_SEND_VEC
  } state_e;

  state_e                state_q;

  // Latched configuration
  logic [DESTW-1:0]      base_q;
  logic [PAIRW-1:0]      num_pairs_q;
  logic [RF_ADDRW-1:0]   rf_addr_q;
  logic [DESTW-1:0]      vec_dest_q;

  // Progress counters
  logic [PAIRW-1:0]      pair_cnt_q;
  logic [LANEW-1:0]      lane_cnt_q;

  // Lower half of the current weight word, held until the upper flit is taken
  logic [DATAW-1:0]      wgt_lo_q;

  // Registered outputs
  logic                  busy_q;
  logic                  done_q;
  logic                  wgt_tready_q;
  logic                  vec_tready_q;
  logic                  tvalid_q;
  logic [DATAW-1:0]      tdata_q;
  logic                  tlast_q;
  logic [USERW-1:0]      tuser_q;
  logic [DESTW-1:0]      tdest_q;

  // Handshake and flit-field helpers
  logic                  m_hs;
  logic                  wgt_hs;
  logic                  vec_hs;
  logic                  last_lane;
  logic                  last_pair;
  logic [DESTW-1:0]      dest_hi;
  logic [DESTW-1:0]      dest_lo;
  logic [LANES-1:0]      lane_onehot;
  logic [USERW-1:0]      wgt_user;
  logic [USERW-1:0]      vec_user;

  assign m_hs   = tvalid_q && AXIS_M_TREADY;
  assign wgt_hs = WGT_TVALID && wgt_tready_q;
  assign vec_hs = VEC_TVALID && vec_tready_q;

  assign last_lane = (lane_cnt_q == LANEW'(LANES - 1));
  assign last_pair = (pair_cnt_q == (num_pairs_q - PAIRW'(1)));

  // Destination arithmetic wraps modulo 2^DESTW by truncation
  assign dest_hi = base_q + DESTW'({pair_cnt_q, 1'b0});
  assign dest_lo = dest_hi + DESTW'(1);

  assign lane_onehot = LANES'(1) << lane_cnt_q;
  assign wgt_user    = USERW'({lane_onehot, OP_WGT, rf_addr_q});
  assign vec_user    = USERW'({LANES'(0), OP_VEC, RF_ADDRW'(0)});

  // Sequencer: state, counters and every output register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      num_pairs_q  <= '0;
      rf_addr_q    <= '0;
      vec_dest_q   <= '0;
      pair_cnt_q   <= '0;
      lane_cnt_q   <= '0;
      wgt_lo_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wgt_tready_q <= 1'b0;
      vec_tready_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      tuser_q      <= '0;
      tdest_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            base_q      <= CFG_BASE_DEST;
            num_pairs_q <= CFG_NUM_PAIRS;
            rf_addr_q   <= CFG_RF_ADDR;
            vec_dest_q  <= CFG_VEC_DEST;
            pair_cnt_q  <= '0;
            lane_cnt_q  <= '0;
            busy_q      <= 1'b1;
            if (CFG_NUM_PAIRS == '0) begin
              state_q      <= S_WAIT_VEC;
              vec_tready_q <= 1'b1;
            end else begin
              state_q      <= S_WAIT_WGT;
              wgt_tready_q <= 1'b1;
            end
          end
        end

        S_WAIT_WGT: begin
          if (wgt_hs) begin
            // Upper half goes out straight away; the lower half waits its turn
            wgt_tready_q <= 1'b0;
            wgt_lo_q     <= WGT_TDATA[DATAW-1:0];
            tvalid_q     <= 1'b1;
            tlast_q      <= 1'b1;
            tdata_q      <= WGT_TDATA[2*DATAW-1:DATAW];
            tuser_q      <= wgt_user;
            tdest_q      <= dest_hi;
            state_q      <= S_SEND_HI;
          end
        end

        S_SEND_HI: begin
          if (m_hs) begin
            tdata_q <= wgt_lo_q;
            tdest_q <= dest_lo;
            state_q <= S_SEND_LO;
          end
        end

        S_SEND_LO: begin
          if (m_hs) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            if (!last_lane) begin
              lane_cnt_q   <= lane_cnt_q + LANEW'(1);
              wgt_tready_q <= 1'b1;
              state_q      <= S_WAIT_WGT;
            end else begin
              lane_cnt_q <= '0;
              pair_cnt_q <= pair_cnt_q + PAIRW'(1);
              if (last_pair) begin
                vec_tready_q <= 1'b1;
                state_q      <= S_WAIT_VEC;
              end else begin
                wgt_tready_q <= 1'b1;
                state_q      <= S_WAIT_WGT;
              end
            end
          end
        end

        S_WAIT_VEC: begin
          if (vec_hs) begin
            vec_tready_q <= 1'b0;
            tvalid_q     <= 1'b1;
            tlast_q      <= 1'b1;
            tdata_q      <= VEC_TDATA;
            tuser_q      <= vec_user;
            tdest_q      <= vec_dest_q;
            state_q      <= S_SEND_VEC;
          end
        end

        S_SEND_VEC: begin
          if (m_hs) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign WGT_TREADY    = wgt_tready_q;
  assign VEC_TREADY    = vec_tready_q;
  assign AXIS_M_TVALID = tvalid_q;
  assign AXIS_M_TDATA  = tdata_q;
  assign AXIS_M_TLAST  = tlast_q;
  assign AXIS_M_TID    = '0;
  assign AXIS_M_TUSER  = tuser_q;
  assign AXIS_M_TDEST  = tdest_q;

endmodule
